// File: rtl/mixer_tdm.sv
// mixer_tdm: time-multiplexed digital mixer.
// Multiplies ADC samples by a per-channel LO value, keeps a gain-selectable
// window of the full product (with extra LSBs for CIC averaging), saturates
// on overflow and tags every result with its round-robin channel index.
// Pipeline: input register -> product -> window/saturate -> output register.
module mixer_tdm #(
  parameter int dwi  = 16,
  parameter int dwlo = 18,
  parameter int davr = 4,
  parameter int nch  = 4,
  parameter int chw  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [dwi-1:0]         adcf,
  input  logic signed [dwlo-1:0]        mult,
  input  logic [1:0]                    shift,
  input  logic                          sat_clr,
  output logic signed [dwi+davr-1:0]    mixout,
  output logic                          out_valid,
  output logic [chw-1:0]                out_ch,
  output logic                          sat_flag
);

  localparam int pw = dwi + dwlo;
  localparam int ow = dwi + davr;

  // The window's low edge must stay inside the product for every shift,
  // and the channel tag must exactly cover the channel count.
  if ((dwlo < davr + 4) || (nch != (1 << chw))) begin : g_bad_params
    $error("mixer_tdm: need dwlo >= davr+4 and nch == 2**chw");
  end

  localparam logic signed [ow-1:0] sat_pos = {1'b0, {(ow-1){1'b1}}};
  localparam logic signed [ow-1:0] sat_neg = {1'b1, {(ow-1){1'b0}}};

  // Channel counter
  logic [chw-1:0]         ch_q, ch_d;
  // Stage 1: input register
  logic                   s1_valid_q, s1_valid_d;
  logic signed [dwi-1:0]  s1_adcf_q, s1_adcf_d;
  logic signed [dwlo-1:0] s1_mult_q, s1_mult_d;
  logic [1:0]             s1_shift_q, s1_shift_d;
  logic [chw-1:0]         s1_ch_q, s1_ch_d;
  // Stage 2: full product
  logic                   s2_valid_q, s2_valid_d;
  logic signed [pw-1:0]   s2_p_q, s2_p_d;
  logic [1:0]             s2_shift_q, s2_shift_d;
  logic [chw-1:0]         s2_ch_q, s2_ch_d;
  // Stage 3: windowed / saturated value
  logic                   s3_valid_q, s3_valid_d;
  logic signed [ow-1:0]   s3_win_q, s3_win_d;
  logic                   s3_sat_q, s3_sat_d;
  logic [chw-1:0]         s3_ch_q, s3_ch_d;
  // Stage 4: output register
  logic                   out_valid_q, out_valid_d;
  logic signed [ow-1:0]   mixout_q, mixout_d;
  logic [chw-1:0]         out_ch_q, out_ch_d;
  logic                   sat_flag_q, sat_flag_d;

  // Combinational helpers
  logic [pw-1:0]          a_ext, m_ext, prod;
  logic signed [pw-1:0]   guard_bits, win_full;
  logic                   overflow;

  // Next-state logic for every pipeline stage, the channel counter and the sticky flag
  always_comb begin
    ch_d        = ch_q;
    s1_valid_d  = in_valid;
    s1_adcf_d   = adcf;
    s1_mult_d   = mult;
    s1_shift_d  = shift;
    s1_ch_d     = ch_q;
    if (in_valid) begin
      ch_d = ch_q + chw'(1);
    end

    a_ext      = {{dwlo{s1_adcf_q[dwi-1]}}, s1_adcf_q};
    m_ext      = {{dwi{s1_mult_q[dwlo-1]}}, s1_mult_q};
    prod       = a_ext * m_ext;
    s2_valid_d = s1_valid_q;
    s2_p_d     = $signed(prod);
    s2_shift_d = s1_shift_q;
    s2_ch_d    = s1_ch_q;

    guard_bits = s2_p_q >>> (pw - 2 - int'(s2_shift_q));
    win_full   = s2_p_q >>> (dwlo - davr - 1 - int'(s2_shift_q));
    overflow   = (guard_bits != '0) && (guard_bits != '1);
    s3_valid_d = s2_valid_q;
    s3_sat_d   = overflow;
    s3_ch_d    = s2_ch_q;
    if (overflow) begin
      s3_win_d = s2_p_q[pw-1] ? sat_neg : sat_pos;
    end else begin
      s3_win_d = win_full[ow-1:0];
    end

    out_valid_d = s3_valid_q;
    mixout_d    = mixout_q;
    out_ch_d    = out_ch_q;
    sat_flag_d  = sat_flag_q;
    if (sat_clr) begin
      sat_flag_d = 1'b0;
    end
    if (s3_valid_q) begin
      mixout_d = s3_win_q;
      out_ch_d = s3_ch_q;
      if (s3_sat_q) begin
        sat_flag_d = 1'b1;
      end
    end
  end

  // State registers; reset flushes everything so in-flight samples never emerge
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_adcf_q   <= '0;
      s1_mult_q   <= '0;
      s1_shift_q  <= '0;
      s1_ch_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_p_q      <= '0;
      s2_shift_q  <= '0;
      s2_ch_q     <= '0;
      s3_valid_q  <= 1'b0;
      s3_win_q    <= '0;
      s3_sat_q    <= 1'b0;
      s3_ch_q     <= '0;
      out_valid_q <= 1'b0;
      mixout_q    <= '0;
      out_ch_q    <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      ch_q        <= ch_d;
      s1_valid_q  <= s1_valid_d;
      s1_adcf_q   <= s1_adcf_d;
      s1_mult_q   <= s1_mult_d;
      s1_shift_q  <= s1_shift_d;
      s1_ch_q     <= s1_ch_d;
      s2_valid_q  <= s2_valid_d;
      s2_p_q      <= s2_p_d;
      s2_shift_q  <= s2_shift_d;
      s2_ch_q     <= s2_ch_d;
      s3_valid_q  <= s3_valid_d;
      s3_win_q    <= s3_win_d;
      s3_sat_q    <= s3_sat_d;
      s3_ch_q     <= s3_ch_d;
      out_valid_q <= out_valid_d;
      mixout_q    <= mixout_d;
      out_ch_q    <= out_ch_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign mixout    = mixout_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_mixer_tdm.sv
// tb_mixer_tdm: directed vectors with hand-computed results pushed into a
// scoreboard queue; an independent monitor pops and compares on out_valid.
module tb_mixer_tdm;

  localparam int dwi  = 16;
  localparam int dwlo = 18;
  localparam int davr = 4;
  localparam int nch  = 4;
  localparam int chw  = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic signed [dwi-1:0]    adcf;
  logic signed [dwlo-1:0]   mult;
  logic [1:0]               shift;
  logic                     sat_clr;
  logic signed [dwi+davr-1:0] mixout;
  logic                     out_valid;
  logic [chw-1:0]           out_ch;
  logic                     sat_flag;

  typedef struct {
    longint mix;
    int     ch;
    bit     sat;
    int     cyc;
  } exp_t;

  exp_t   sb_q[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     model_ch = 0;
  bit     model_flag = 1'b0;
  longint last_mix = 0;
  int     last_ch = 0;

  mixer_tdm #(
    .dwi(dwi), .dwlo(dwlo), .davr(davr), .nch(nch), .chw(chw)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .adcf(adcf),
    .mult(mult),
    .shift(shift),
    .sat_clr(sat_clr),
    .mixout(mixout),
    .out_valid(out_valid),
    .out_ch(out_ch),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Presents one sample in the next cycle and records its expected result.
  task automatic applyStimulus(input int a, input int m, input int s,
                               input longint mix_exp, input bit sat_exp);
    @(negedge clk);
    adcf     = dwi'(a);
    mult     = dwlo'(m);
    shift    = 2'(s);
    in_valid = 1'b1;
    sb_q.push_back('{mix_exp, model_ch, sat_exp, cyc});
    model_ch = (model_ch + 1) % nch;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    in_valid = 1'b0;
    sat_clr  = 1'b1;
    @(negedge clk);
    sat_clr  = 1'b0;
  endtask

  // Monitor: cycle n is the interval after posedge n; a result issued in
  // cycle c is due in cycle c+4.
  always @(posedge clk) begin
    static bit   clr_s;
    static bit   rst_s;
    static exp_t e;
    clr_s = sat_clr;
    rst_s = rst;
    cyc++;
    #1;
    if (rst_s) begin
      model_flag = 1'b0;
      last_mix   = 0;
      last_ch    = 0;
    end else if (out_valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_out_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("mixout", mixout, e.mix);
        checkOutput("out_ch", out_ch, e.ch);
        checkOutput("latency", cyc, e.cyc + 4);
        if (e.sat) model_flag = 1'b1;
        else if (clr_s) model_flag = 1'b0;
        checkOutput("sat_flag", sat_flag, model_flag);
        last_mix = e.mix;
        last_ch  = e.ch;
      end
    end else begin
      checkOutput("hold_mixout", mixout, last_mix);
      checkOutput("hold_out_ch", out_ch, last_ch);
      if (clr_s) model_flag = 1'b0;
      checkOutput("sat_flag_idle", sat_flag, model_flag);
    end
  end

  initial begin
    int guard;
    rst      = 1'b1;
    in_valid = 1'b0;
    adcf     = '0;
    mult     = '0;
    shift    = '0;
    sat_clr  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_mixout", mixout, 0);
    checkOutput("reset_out_ch", out_ch, 0);
    checkOutput("reset_sat_flag", sat_flag, 0);
    rst = 1'b0;

    // Single sample, unity-style gain: 2^30 >> 13 = 131072
    applyStimulus(16384, 65536, 0, 131072, 1'b0);
    idle(6);

    // Same sample with shift=2 overflows to +max and sets the sticky flag
    applyStimulus(16384, 65536, 2, 524287, 1'b1);
    idle(8);
    checkOutput("sat_flag_sticky", sat_flag, 1);
    pulse_clr();
    checkOutput("sat_flag_cleared", sat_flag, 0);

    // Back-to-back boundary vectors, shift changing per sample
    applyStimulus(-32768, 131071, 0, -524284, 1'b0);
    applyStimulus(-32768, -131072, 0, 524287, 1'b1);
    applyStimulus(-1, 1, 0, -1, 1'b0);
    applyStimulus(1, 8191, 0, 0, 1'b0);
    applyStimulus(-32768, 131071, 1, -524288, 1'b1);
    applyStimulus(16384, 65536, 1, 262144, 1'b0);
    applyStimulus(1024, 65536, 3, 65536, 1'b0);
    idle(6);
    pulse_clr();

    // Saturation arriving in the same cycle as sat_clr: set wins
    applyStimulus(16384, 65536, 2, 524287, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    checkOutput("set_beats_clear", sat_flag, 1);
    idle(4);

    // Reset with three samples in flight: none may emerge
    applyStimulus(7777, 8192, 0, 7777, 1'b0);
    applyStimulus(7777, 8192, 0, 7777, 1'b0);
    applyStimulus(7777, 8192, 0, 7777, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    sb_q.delete();
    model_ch = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_mixout", mixout, 0);
    checkOutput("rst_out_ch", out_ch, 0);
    checkOutput("rst_sat_flag", sat_flag, 0);
    rst = 1'b0;
    idle(5);

    // Six consecutive samples: tags 0,1,2,3,0,1
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(k * 1000, 8192, 0, longint'(k * 1000), 1'b0);
    end
    // Three samples, a bubble, three more: tags 2,3,0,1,2,3
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(-100 * k, 8192, 0, longint'(-100 * k), 1'b0);
    end
    idle(1);
    for (int k = 4; k <= 6; k++) begin
      applyStimulus(-100 * k, 8192, 0, longint'(-100 * k), 1'b0);
    end
    idle(1);

    guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      checkOutput("drain_timeout", sb_q.size(), 0);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
